rgb2bw_stream: RTL
==================

Name: rgb2bw_stream

Overview:
Parametrised, pipelined successor to the combinational RGB-to-BW converter. It accepts one RGB pixel per beat on a valid/ready stream and produces a weighted grayscale sum, a rounded gray value, or a thresholded binary (black/white) pixel. It also tracks line position for the downstream frame writer. It sits between the pixel source (image reader/deserialiser) and the output framebuffer.

Parameters:
PIX_W, 8, bits per colour channel and per output gray pixel
COEF_W, 7, coefficient fraction bits; all weight sets sum to 2**COEF_W
LINE_W, 640, pixels per line; used for out_eol generation (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept the input beat
in_red  in  PIX_W  red channel
in_green  in  PIX_W  green channel
in_blue  in  PIX_W  blue channel
in_sof  in  1  first pixel of frame; travels with the pixel
mode  in  2  0=luma, 1=average, 2=threshold BW, 3=reserved (acts as 0); sampled per beat
thresh  in  PIX_W  threshold for mode 2; sampled per beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the output beat
out_sum  out  PIX_W+COEF_W  raw weighted sum (15 bits at defaults)
out_gray  out  PIX_W  rounded gray, or 0 / all-ones in mode 2
out_sof  out  1  delayed in_sof
out_eol  out  1  last pixel of line
out_col  out  clog2(LINE_W)  column index of the current output beat

Behaviour:
- Reset: out_valid=0, out_sum=0, out_gray=0, out_sof=0, out_eol=0, out_col=0. All stage valids are cleared. in_ready=1 in the cycle after rst deasserts. Reset mid-stream discards all in-flight pixels without emitting them.
- Three-stage pipeline, S1 -> S2 -> S3. Latency is 3 cycles from input handshake to out_valid with no backpressure. Throughput is 1 pixel/clk.
- Stall rule: en = ~out_valid | out_ready, and in_ready = en. When en=0 every stage holds, including data, mode, thresh and sof. When en=1 every stage advances, and bubbles advance too.
- S1 registers the channels, mode, thresh and sof, with valid = in_valid & in_ready.
- S2 forms three PIX_W x COEF_W products from the mode weight set:
  - luma: R=38, G=75, B=15
  - average: R=43, G=43, B=42
- S3 computes:
  - sum = pR+pG+pB, width PIX_W+COEF_W, which cannot overflow because the weights sum to 2**COEF_W.
  - gray = (sum + 2**(COEF_W-1)) >> COEF_W, saturated to 2**PIX_W-1.
  - Mode 2 uses the luma weights, then sets out_gray = all-ones if gray >= thresh, else 0. out_sum still carries the luma sum.
- Column counter, updated on the output handshake (out_valid & out_ready):
  - A beat with out_sof=1 has out_col=0 and restarts the count, even mid-line.
  - After each handshake col increments and wraps to 0 after LINE_W-1.
  - out_eol = (out_col == LINE_W-1), combinational from the registered counter and valid only with out_valid.
- Output data is stable while out_valid=1 and out_ready=0 (AXI-style hold). No beat is dropped or duplicated.
- Simultaneous events:
  - in handshake and out handshake in the same cycle: both occur and the pipeline advances.
  - rst has priority over all handshakes.

Decomposition:
- Package rgb2bw_pkg holds:
  - mode encodings MODE_LUMA=0, MODE_AVG=1, MODE_BW=2
  - weight constants W_LUMA_R/G/B and W_AVG_R/G/B at COEF_W=7
  - a stage-payload struct typedef (channels, mode, thresh, sof)
- One sub-module, rgb2bw_wsum: S2+S3 weighted sum, rounding and threshold datapath, with an enable input. It is instantiated once.
- Handshake and column counter stay in the top.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> all outputs 0 and no out_valid. First output appears exactly 3 cycles after the first post-reset handshake.
- Luma mode:
  - (255,255,255) -> out_sum=32640, out_gray=255
  - (255,0,0) -> out_sum=9690, out_gray=76
  - (0,0,0) -> out_sum=0, out_gray=0
- Average mode, (10,20,30) -> out_sum=2550, out_gray=20.
- Threshold mode, thresh=128:
  - (128,128,128) -> out_gray=255
  - (127,127,127) -> out_gray=0, out_sum=16256
- Backpressure: stream 10 distinct pixels, hold out_ready=0 for 5 cycles mid-stream -> in_ready drops once 3 beats are held. Outputs stay stable, and all 10 are delivered in order with none lost or duplicated.
- Line tracking with LINE_W=4: sof on beat 0, 9 beats, then sof again on beat 6 -> out_col 0,1,2,3,0,1,0,1,2, and out_eol on beat 3 only. Also assert rst mid-line -> out_col returns to 0.

Source files
------------

// File: rtl/rgb2bw_pkg.sv
// rgb2bw_pkg: shared types and constants for the rgb2bw_stream pixel pipeline.
//   mode_e : per-beat conversion mode (luma, average, threshold BW, reserved)
//   W_*    : channel weights; each set sums to 2**P_COEF_W
//   pix_t  : payload carried by pipeline stage S1 (channels, mode, thresh, sof)
package rgb2bw_pkg;

  localparam int P_PIX_W  = 8;
  localparam int P_COEF_W = 7;

  typedef enum logic [1:0] {
    MODE_LUMA = 2'd0,
    MODE_AVG  = 2'd1,
    MODE_BW   = 2'd2,
    MODE_RSVD = 2'd3   // treated as luma
  } mode_e;

  localparam logic [P_COEF_W-1:0] W_LUMA_R = 7'd38;
  localparam logic [P_COEF_W-1:0] W_LUMA_G = 7'd75;
  localparam logic [P_COEF_W-1:0] W_LUMA_B = 7'd15;
  localparam logic [P_COEF_W-1:0] W_AVG_R  = 7'd43;
  localparam logic [P_COEF_W-1:0] W_AVG_G  = 7'd43;
  localparam logic [P_COEF_W-1:0] W_AVG_B  = 7'd42;

  typedef struct packed {
    logic [P_PIX_W-1:0] r;
    logic [P_PIX_W-1:0] g;
    logic [P_PIX_W-1:0] b;
    mode_e              mode;
    logic [P_PIX_W-1:0] thresh;
    logic               sof;
  } pix_t;

endpackage

// File: rtl/rgb2bw_wsum.sv
// rgb2bw_wsum: stages S2 and S3 of the converter datapath.
//   S2 forms the three weighted channel products for the beat's mode.
//   S3 adds them, rounds to PIX_W bits with saturation, and applies the
//   threshold in BW mode. Both stages load only when en_i is high.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   en_i       pipeline advance enable
//   s1_i       S1 payload
//   sum_o      registered raw weighted sum
//   gray_o     registered gray / binary pixel
//   sof_o      registered start-of-frame, aligned with sum_o/gray_o
module rgb2bw_wsum
  import rgb2bw_pkg::*;
#(
  parameter int PIX_W  = P_PIX_W,
  parameter int COEF_W = P_COEF_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  pix_t                    s1_i,
  output logic [PIX_W+COEF_W-1:0] sum_o,
  output logic [PIX_W-1:0]        gray_o,
  output logic                    sof_o
);

  localparam int SUM_W = PIX_W + COEF_W;
  localparam logic [SUM_W:0] RND = (SUM_W+1)'(2**(COEF_W-1));

  // S2: weight selection and products
  logic [COEF_W-1:0] wr, wg, wb;
  always_comb begin
    wr = W_LUMA_R;
    wg = W_LUMA_G;
    wb = W_LUMA_B;
    if (s1_i.mode == MODE_AVG) begin
      wr = W_AVG_R;
      wg = W_AVG_G;
      wb = W_AVG_B;
    end
  end

  logic [SUM_W-1:0] pr_q, pg_q, pb_q;
  logic [PIX_W-1:0] thr_q;
  logic             bw_q, sof2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pr_q   <= '0;
      pg_q   <= '0;
      pb_q   <= '0;
      thr_q  <= '0;
      bw_q   <= 1'b0;
      sof2_q <= 1'b0;
    end else if (en_i) begin
      pr_q   <= SUM_W'(s1_i.r) * SUM_W'(wr);
      pg_q   <= SUM_W'(s1_i.g) * SUM_W'(wg);
      pb_q   <= SUM_W'(s1_i.b) * SUM_W'(wb);
      thr_q  <= s1_i.thresh;
      bw_q   <= (s1_i.mode == MODE_BW);
      sof2_q <= s1_i.sof;
    end
  end

  // S3: sum, round-half-up, saturate, optional threshold
  logic [SUM_W-1:0] sum_d;
  logic [SUM_W:0]   rnd;
  logic [PIX_W:0]   gray_r;
  logic [PIX_W-1:0] gray_sat, gray_d;

  always_comb begin
    sum_d    = pr_q + pg_q + pb_q;
    rnd      = {1'b0, sum_d} + RND;
    gray_r   = (PIX_W+1)'(rnd >> COEF_W);
    gray_sat = gray_r[PIX_W] ? '1 : gray_r[PIX_W-1:0];
    gray_d   = gray_sat;
    if (bw_q) gray_d = (gray_sat >= thr_q) ? '1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_o  <= '0;
      gray_o <= '0;
      sof_o  <= 1'b0;
    end else if (en_i) begin
      sum_o  <= sum_d;
      gray_o <= gray_d;
      sof_o  <= sof2_q;
    end
  end

endmodule

// File: rtl/rgb2bw_stream.sv
// rgb2bw_stream: 3-stage valid/ready RGB to grayscale / BW converter with
// line-column tracking for the downstream frame writer.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready                input handshake
//   in_red/in_green/in_blue, in_sof  input pixel and start-of-frame
//   mode, thresh                     per-beat conversion controls
//   out_valid/out_ready              output handshake
//   out_sum, out_gray, out_sof       converted pixel
//   out_eol, out_col                 line position of the current output beat
// The payload struct is sized by the package, so PIX_W/COEF_W must stay at
// the package values.
module rgb2bw_stream
  import rgb2bw_pkg::*;
#(
  parameter int PIX_W  = P_PIX_W,
  parameter int COEF_W = P_COEF_W,
  parameter int LINE_W = 640
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PIX_W-1:0]           in_red,
  input  logic [PIX_W-1:0]           in_green,
  input  logic [PIX_W-1:0]           in_blue,
  input  logic                       in_sof,
  input  logic [1:0]                 mode,
  input  logic [PIX_W-1:0]           thresh,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PIX_W+COEF_W-1:0]    out_sum,
  output logic [PIX_W-1:0]           out_gray,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic [$clog2(LINE_W)-1:0]  out_col
);

  localparam int COL_W = $clog2(LINE_W);
  localparam logic [COL_W-1:0] LAST = COL_W'(LINE_W - 1);

  // Whole-pipe stall: everything holds while the output beat waits.
  logic       en;
  logic [3:1] vld_pipe_q;
  pix_t       s1_q;

  assign en        = ~vld_pipe_q[3] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe_q[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
    end else if (en) begin
      vld_pipe_q <= {vld_pipe_q[2:1], in_valid};
      s1_q       <= '{r: in_red, g: in_green, b: in_blue, mode: mode_e'(mode),
                      thresh: thresh, sof: in_sof};
    end
  end

  rgb2bw_wsum #(.PIX_W(PIX_W), .COEF_W(COEF_W)) u_wsum (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en),
    .s1_i   (s1_q),
    .sum_o  (out_sum),
    .gray_o (out_gray),
    .sof_o  (out_sof)
  );

  // col_q is the column the next beat takes unless it carries sof.
  logic [COL_W-1:0] col_q;

  assign out_col = out_sof ? '0 : col_q;
  assign out_eol = out_valid & (out_col == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
    end else if (out_valid & out_ready) begin
      col_q <= (out_col == LAST) ? '0 : out_col + 1'b1;
    end
  end

endmodule
